instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL provide parameter HALT_CODE, default 9'b111111111, the machine word that stops fetch.
REQ-002 SHALL provide parameter LUT_DEPTH, default 32, the number of branch-target LUT entries.
REQ-003 SHALL have port Clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins fetch at start_addr; honoured only in IDLE or DONE.
REQ-006 SHALL have port start_addr  input  8  first fetch address.
REQ-007 SHALL have port stall  input  1  freezes all fetch state while high.
REQ-008 SHALL have port branch_taken  input  1  redirects the PC this cycle.
REQ-009 SHALL have port target_idx  input  5  branch-target LUT index.
REQ-010 SHALL have port jump_rel  input  1  selects target mode: 1 = relative (LUT value is a signed offset), 0 = absolute.
REQ-011 SHALL have port mach_code  input  9  instruction word returned combinationally by the instruction ROM for prog_ctr.
REQ-012 SHALL have port prog_ctr  output  8  registered fetch address that drives the instruction ROM.
REQ-013 SHALL have port instr  output  9  registered fetched instruction.
REQ-014 SHALL have port instr_valid  output  1  instr holds a live, non-squashed instruction.
REQ-015 SHALL have port busy  output  1  high while in state RUN.
REQ-016 SHALL have port done  output  1  high while in state DONE.

Function
REQ-017 SHALL implement states IDLE, RUN and DONE.
REQ-018 IDLE/DONE with start=1 SHALL: load prog_ctr<=start_addr; clear instr_valid and done; go to RUN.
REQ-019 IDLE/DONE with start=0 SHALL hold all outputs.
REQ-020 RUN with stall=1 SHALL hold prog_ctr, instr, instr_valid and state; branch_taken is ignored. Execute holds branch_taken until stall falls.
REQ-021 RUN, stall=0, branch_taken=1 SHALL: set prog_ctr<=target; set instr_valid<=0 (squash fall-through word); leave instr unchanged.
REQ-022 Branch target SHALL be lut[target_idx] when jump_rel=0.
REQ-023 Branch target SHALL be (prog_ctr + sign-extended lut[target_idx]) mod 256 when jump_rel=1.
REQ-024 RUN, stall=0, branch_taken=0, mach_code==HALT_CODE SHALL: hold prog_ctr; set instr_valid<=0; go to DONE.
REQ-025 RUN, stall=0, branch_taken=0, other mach_code SHALL: set instr<=mach_code, instr_valid<=1, prog_ctr<=prog_ctr+1.
REQ-026 Branch SHALL take priority over halt detection in the same cycle, because the halt word is then in the squashed slot.
REQ-027 prog_ctr increment and relative targets SHALL wrap modulo 256 (8'hFF+1 -> 8'h00).
REQ-028 Fetch latency SHALL be one cycle: the word at address A appears on instr with instr_valid=1 on the edge after prog_ctr==A is fetched.
REQ-029 busy SHALL equal (state==RUN); done SHALL equal (state==DONE); both SHALL be registered or decoded directly from the state register, glitch-free.

Reset
REQ-030 Reset=1 at a rising edge SHALL force state IDLE, prog_ctr=8'h00, instr=9'h000, instr_valid=0, busy=0, done=0, regardless of stall, start or branch_taken.
REQ-031 Reset SHALL take effect mid-RUN with no squash or drain cycles; the first start after release SHALL behave per REQ-018.

Structure
REQ-032 A shared package SHALL hold the state enum, HALT_CODE, the LUT contents, and bench constants: LUT[3]=8'h40, LUT[5]=8'hFC (-4).
REQ-033 The branch-target table SHALL be a separate combinational sub-module pc_lut: target_idx in, 8-bit value out.

Verification
REQ-034 Sequential fetch: start, start_addr=8'h10; ROM words 9'h001, 9'h002 -> prog_ctr 10,11,12 on successive edges; instr 9'h001 with instr_valid=1 one cycle after entering RUN.
REQ-035 Absolute branch: at prog_ctr=8'h12, branch_taken=1, target_idx=3, jump_rel=0 -> next prog_ctr=8'h40, instr_valid=0 for one cycle, then fetch resumes at 8'h41.
REQ-036 Relative branch with wrap: at prog_ctr=8'h02, target_idx=5, jump_rel=1 -> prog_ctr=8'hFE, then 8'hFF, then 8'h00.
REQ-037 Halt: mach_code=9'h1FF at prog_ctr=8'h14 -> done=1, busy=0, prog_ctr stays 8'h14, instr_valid=0; a new start with start_addr=8'h00 re-enters RUN.
REQ-038 Stall: stall high for 3 cycles with branch_taken=1 at prog_ctr=8'h30 -> prog_ctr, instr and instr_valid unchanged for all 3 cycles, no redirect.
REQ-039 Reset mid-run: Reset at prog_ctr=8'h23 with branch_taken=1 -> next edge prog_ctr=8'h00, IDLE, instr_valid=0, done=0.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Also holds the branch-target table contents.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic [8:0]  HaltCode = 9'h1FF;
    localparam int unsigned LutDepth = 32;

    // Known table entries that directed tests rely on
    localparam logic [7:0] LutAbsTarget = 8'h40;  // entry 3
    localparam logic [7:0] LutRelOffset = 8'hFC;  // entry 5, -4

    function automatic logic [7:0] lut_value(input logic [4:0] idx);
        logic [7:0] val;
        val = 8'h00;
        case (idx)
            5'd0:    val = 8'h00;
            5'd1:    val = 8'h08;
            5'd2:    val = 8'h23;
            5'd3:    val = LutAbsTarget;
            5'd4:    val = 8'h80;
            5'd5:    val = LutRelOffset;
            5'd6:    val = 8'hF8;
            5'd7:    val = 8'h30;
            default: val = 8'h00;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: control from the core, ROM word in, fetch state out.
interface instr_fetch_if;

    logic       start;
    logic [7:0] start_addr;
    logic       stall;
    logic       branch_taken;
    logic [4:0] target_idx;
    logic       jump_rel;
    logic [8:0] mach_code;
    logic [7:0] prog_ctr;
    logic [8:0] instr;
    logic       instr_valid;
    logic       busy;
    logic       done;

    modport master (
        output start, start_addr, stall, branch_taken, target_idx, jump_rel, mach_code,
        input  prog_ctr, instr, instr_valid, busy, done
    );

    modport slave (
        input  start, start_addr, stall, branch_taken, target_idx, jump_rel, mach_code,
        output prog_ctr, instr, instr_valid, busy, done
    );

endinterface

// File: rtl/pc_lut.sv
// Combinational branch-target table; indices past the configured depth read zero.
module pc_lut
    import instr_fetch_pkg::*;
#(
    parameter int unsigned Depth = LutDepth
) (
    input  logic [4:0] target_idx_i,
    output logic [7:0] value_o
);

    always_comb begin
        value_o = 8'h00;
        if (int'(target_idx_i) < Depth) begin
            value_o = lut_value(target_idx_i);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: sequential PC with LUT branches, halt detection and stall.
// instr lags prog_ctr by one cycle; a taken branch squashes the fall-through slot.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [8:0]  HALT_CODE = HaltCode,
    parameter int unsigned LUT_DEPTH = LutDepth
) (
    input  logic              Clk,
    input  logic              Reset,
    instr_fetch_if.slave      bus
);

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [8:0] instr_q, instr_d;
    logic       valid_q, valid_d;
    logic [7:0] lut_val;

    pc_lut #(
        .Depth (LUT_DEPTH)
    ) u_pc_lut (
        .target_idx_i (bus.target_idx),
        .value_o      (lut_val)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    pc_d    = bus.start_addr;
                    valid_d = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!bus.stall) begin
                    // Branch wins: a halt word here sits in the squashed slot
                    if (bus.branch_taken) begin
                        pc_d    = bus.jump_rel ? pc_q + lut_val : lut_val;
                        valid_d = 1'b0;
                    end else if (bus.mach_code == HALT_CODE) begin
                        valid_d = 1'b0;
                        state_d = StDone;
                    end else begin
                        instr_d = bus.mach_code;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            pc_q    <= 8'h00;
            instr_q <= 9'h000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign bus.prog_ctr    = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.busy        = (state_q == StRun);
    assign bus.done        = (state_q == StDone);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a small modelled instruction ROM.
module tb_instr_fetch;

    logic Clk;
    logic Reset;
    logic [8:0] rom [256];
    int n_vec;
    int n_err;

    instr_fetch_if bus ();

    assign bus.mach_code = rom[bus.prog_ctr];

    instr_fetch #(
        .HALT_CODE (9'h1FF),
        .LUT_DEPTH (32)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [7:0] pc, input logic [8:0] ins,
                               input logic vld, input logic bsy, input logic dn);
        check_eq({tag, ".pc"}, 16'(bus.prog_ctr), 16'(pc));
        check_eq({tag, ".instr"}, 16'(bus.instr), 16'(ins));
        check_eq({tag, ".valid"}, 16'(bus.instr_valid), 16'(vld));
        check_eq({tag, ".busy"}, 16'(bus.busy), 16'(bsy));
        check_eq({tag, ".done"}, 16'(bus.done), 16'(dn));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) rom[i] = 9'h055;
        rom[8'h10] = 9'h001;
        rom[8'h11] = 9'h002;
        rom[8'h40] = 9'h0AB;
        rom[8'h41] = 9'h1FF;
        rom[8'h13] = 9'h0C0;
        rom[8'h14] = 9'h1FF;
        rom[8'h00] = 9'h111;
        rom[8'h01] = 9'h112;
        rom[8'hFE] = 9'h0FE;
        rom[8'hFF] = 9'h0EE;
        rom[8'h30] = 9'h130;
        rom[8'h31] = 9'h131;

        Reset = 1'b1;
        bus.start = 1'b1;
        bus.start_addr = 8'h77;
        bus.stall = 1'b0;
        bus.branch_taken = 1'b1;
        bus.target_idx = 5'd3;
        bus.jump_rel = 1'b0;
        step();
        check_state("reset", 8'h00, 9'h000, 1'b0, 1'b0, 1'b0);
        Reset = 1'b0;
        bus.start = 1'b0;
        bus.branch_taken = 1'b0;
        step();
        check_state("idle_hold", 8'h00, 9'h000, 1'b0, 1'b0, 1'b0);

        // Sequential fetch from 0x10
        bus.start = 1'b1;
        bus.start_addr = 8'h10;
        step();
        check_state("seq0", 8'h10, 9'h000, 1'b0, 1'b1, 1'b0);
        bus.start = 1'b0;
        step();
        check_state("seq1", 8'h11, 9'h001, 1'b1, 1'b1, 1'b0);
        step();
        check_state("seq2", 8'h12, 9'h002, 1'b1, 1'b1, 1'b0);

        // Absolute branch via entry 3
        bus.branch_taken = 1'b1;
        bus.target_idx = 5'd3;
        bus.jump_rel = 1'b0;
        step();
        check_state("abs_br", 8'h40, 9'h002, 1'b0, 1'b1, 1'b0);
        bus.branch_taken = 1'b0;
        step();
        check_state("abs_resume", 8'h41, 9'h0AB, 1'b1, 1'b1, 1'b0);
        step();
        check_state("halt41", 8'h41, 9'h0AB, 1'b0, 1'b0, 1'b1);

        // Restart from DONE and halt at 0x14
        bus.start = 1'b1;
        bus.start_addr = 8'h13;
        step();
        check_state("rst13", 8'h13, 9'h0AB, 1'b0, 1'b1, 1'b0);
        bus.start = 1'b0;
        step();
        check_state("f13", 8'h14, 9'h0C0, 1'b1, 1'b1, 1'b0);
        step();
        check_state("halt14", 8'h14, 9'h0C0, 1'b0, 1'b0, 1'b1);
        step();
        check_state("done_hold", 8'h14, 9'h0C0, 1'b0, 1'b0, 1'b1);

        bus.start = 1'b1;
        bus.start_addr = 8'h00;
        step();
        check_state("start00", 8'h00, 9'h0C0, 1'b0, 1'b1, 1'b0);
        bus.start = 1'b0;
        step();
        check_state("f00", 8'h01, 9'h111, 1'b1, 1'b1, 1'b0);
        step();
        check_state("f01", 8'h02, 9'h112, 1'b1, 1'b1, 1'b0);

        // Relative branch -4 from 0x02 and wrap past 0xFF
        bus.branch_taken = 1'b1;
        bus.target_idx = 5'd5;
        bus.jump_rel = 1'b1;
        step();
        check_state("rel_br", 8'hFE, 9'h112, 1'b0, 1'b1, 1'b0);
        bus.branch_taken = 1'b0;
        step();
        check_state("fFE", 8'hFF, 9'h0FE, 1'b1, 1'b1, 1'b0);
        step();
        check_state("wrap", 8'h00, 9'h0EE, 1'b1, 1'b1, 1'b0);

        // Branch to 0x30 (entry 7), then stall with a pending branch
        bus.branch_taken = 1'b1;
        bus.target_idx = 5'd7;
        bus.jump_rel = 1'b0;
        step();
        check_state("br30", 8'h30, 9'h0EE, 1'b0, 1'b1, 1'b0);
        bus.stall = 1'b1;
        bus.target_idx = 5'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            check_state($sformatf("stall%0d", i), 8'h30, 9'h0EE, 1'b0, 1'b1, 1'b0);
        end
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        step();
        check_state("unstall", 8'h31, 9'h130, 1'b1, 1'b1, 1'b0);

        // Reach 0x23 then reset with a branch pending
        bus.branch_taken = 1'b1;
        bus.target_idx = 5'd2;
        step();
        check_state("br23", 8'h23, 9'h130, 1'b0, 1'b1, 1'b0);
        Reset = 1'b1;
        bus.target_idx = 5'd3;
        step();
        check_state("mid_reset", 8'h00, 9'h000, 1'b0, 1'b0, 1'b0);
        Reset = 1'b0;
        bus.branch_taken = 1'b0;
        bus.start = 1'b1;
        bus.start_addr = 8'h10;
        step();
        check_state("post_reset", 8'h10, 9'h000, 1'b0, 1'b1, 1'b0);
        bus.start = 1'b0;
        step();
        check_state("post_f10", 8'h11, 9'h001, 1'b1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
